truco_placar_multi: RTL and testbench

Parametrised Truco scoreboard for N teams (2–4). It replaces the fixed two-team scoreboard.
- Synchronises and edge-detects raw push-buttons internally.
- Adds a bet ("truco") mechanism: each hand is worth 1/3/6/9/12 points.
- Counts points to PTS_MAX and rounds won (tentos) to TENTOS_MAX.
- Drives registered 7-segment digits per team.
Sits directly under the board top level, between the buttons and the displays.

---
 rtl/truco_pkg.sv | 33 +++
 rtl/truco_btn_sync.sv | 30 +++
 rtl/truco_placar_multi.sv | 183 ++++++++++++++++++
 tb/tb_truco_placar_multi.sv | 275 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/truco_pkg.sv
// Shared types, segment patterns and the bet ladder for the Truco scoreboard.
package truco_pkg;

    typedef enum logic [1:0] {
        JOGO   = 2'd0,
        RODADA = 2'd1,
        FIM    = 2'd2
    } estado_t;

    localparam logic [6:0] SEG_BLANK = 7'b1111111;

    // Active-low gfedcba patterns for digits 0..9.
    localparam logic [6:0] SEG7 [0:9] = '{
        7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001,
        7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000, 7'b0010000
    };

    function automatic logic [3:0] proxima_aposta(input logic [3:0] valor);
        case (valor)
            4'd1:    return 4'd3;
            4'd3:    return 4'd6;
            4'd6:    return 4'd9;
            default: return 4'd12;
        endcase
    endfunction

    function automatic logic [6:0] seg7_code(input logic [7:0] digito);
        if (digito <= 8'd9)
            return SEG7[digito[3:0]];
        return SEG_BLANK;
    endfunction

endpackage

// File: rtl/truco_btn_sync.sv
// Two-flop synchroniser followed by a registered rising-edge detector:
// one clean single-cycle pulse per press, nothing while the button is held.
module truco_btn_sync #(
    parameter int W = 1
) (
    input  logic         clk,
    input  logic         reset,
    input  logic [W-1:0] raw,
    output logic [W-1:0] pulse
);

    logic [W-1:0] meta;
    logic [W-1:0] sync;
    logic [W-1:0] sync_d;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            meta   <= '0;
            sync   <= '0;
            sync_d <= '0;
            pulse  <= '0;
        end else begin
            meta   <= raw;
            sync   <= meta;
            sync_d <= sync;
            pulse  <= sync & ~sync_d;
        end
    end

endmodule

// File: rtl/truco_placar_multi.sv
// N-team Truco scoreboard with bet raising, round (tento) tracking and
// registered 7-segment outputs per team.
//
//   state  | meaning
//   JOGO   | hand in play: scoring and bet pulses accepted
//   RODADA | one cycle: clear points, credit the tento to the scoring team
//   FIM    | game over, counters frozen until novo_jogo
module truco_placar_multi
    import truco_pkg::*;
#(
    parameter  int N_TEAMS    = 2,
    parameter  int PTS_MAX    = 12,
    parameter  int TENTOS_MAX = 3,
    localparam int PW         = $clog2(PTS_MAX + 1),
    localparam int TW         = $clog2(TENTOS_MAX + 1)
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [N_TEAMS-1:0]    btn,
    input  logic                  btn_truco,
    input  logic                  novo_jogo,
    output logic [N_TEAMS*PW-1:0] pontos,
    output logic [N_TEAMS*TW-1:0] tentos,
    output logic [3:0]            valor_mao,
    output logic                  fim_jogo,
    output logic [1:0]            vencedor,
    output logic [N_TEAMS*7-1:0]  seg_dez,
    output logic [N_TEAMS*7-1:0]  seg_und,
    output logic [N_TEAMS*7-1:0]  seg_tento
);

    // Sum is wide enough for the bet value even when PW is tiny.
    localparam int SW = ((PW > 4) ? PW : 4) + 1;
    localparam int NI = N_TEAMS + 2;

    logic [NI-1:0]      raw_in;
    logic [NI-1:0]      pulso;
    logic [N_TEAMS-1:0] p_btn;
    logic               p_truco;
    logic               p_novo;

    assign raw_in  = {novo_jogo, btn_truco, btn};
    assign p_btn   = pulso[N_TEAMS-1:0];
    assign p_truco = pulso[N_TEAMS];
    assign p_novo  = pulso[N_TEAMS+1];

    truco_btn_sync #(.W(NI)) u_sync (
        .clk   (clk),
        .reset (reset),
        .raw   (raw_in),
        .pulse (pulso)
    );

    estado_t       estado, estado_n;
    logic [PW-1:0] pts_q [N_TEAMS];
    logic [PW-1:0] pts_n [N_TEAMS];
    logic [TW-1:0] tnt_q [N_TEAMS];
    logic [TW-1:0] tnt_n [N_TEAMS];
    logic [3:0]    valor_q, valor_n;
    logic [1:0]    venc_q, venc_n;
    logic [1:0]    lider_q, lider_n;
    logic          achou;
    logic [SW-1:0] soma;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            estado <= JOGO;
        else
            estado <= estado_n;
    end

    always_comb begin
        estado_n = estado;
        pts_n    = pts_q;
        tnt_n    = tnt_q;
        valor_n  = valor_q;
        venc_n   = venc_q;
        lider_n  = lider_q;
        achou    = 1'b0;
        soma     = '0;

        if (p_novo) begin
            estado_n = JOGO;
            for (int i = 0; i < N_TEAMS; i++) begin
                pts_n[i] = '0;
                tnt_n[i] = '0;
            end
            valor_n = 4'd1;
            venc_n  = '0;
        end else begin
            case (estado)
                JOGO: begin
                    // Lowest-index button wins a same-cycle tie.
                    for (int i = 0; i < N_TEAMS; i++) begin
                        if (p_btn[i] && !achou) begin
                            achou   = 1'b1;
                            lider_n = 2'(i);
                            soma    = SW'(pts_q[i]) + SW'(valor_q);
                            if (soma >= SW'(PTS_MAX)) begin
                                pts_n[i] = PW'(PTS_MAX);
                                estado_n = RODADA;
                            end else begin
                                pts_n[i] = soma[PW-1:0];
                            end
                        end
                    end
                    if (achou)
                        valor_n = 4'd1;
                    else if (p_truco)
                        valor_n = proxima_aposta(valor_q);
                end
                RODADA: begin
                    estado_n = JOGO;
                    for (int i = 0; i < N_TEAMS; i++) begin
                        pts_n[i] = '0;
                        if (2'(i) == lider_q) begin
                            tnt_n[i] = tnt_q[i] + 1'b1;
                            if (tnt_q[i] == TW'(TENTOS_MAX - 1)) begin
                                estado_n = FIM;
                                venc_n   = lider_q;
                            end
                        end
                    end
                end
                FIM: begin
                end
                default: estado_n = JOGO;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < N_TEAMS; i++) begin
                pts_q[i] <= '0;
                tnt_q[i] <= '0;
            end
            valor_q <= 4'd1;
            venc_q  <= '0;
            lider_q <= '0;
        end else begin
            pts_q   <= pts_n;
            tnt_q   <= tnt_n;
            valor_q <= valor_n;
            venc_q  <= venc_n;
            lider_q <= lider_n;
        end
    end

    assign valor_mao = valor_q;
    assign fim_jogo  = (estado == FIM);
    assign vencedor  = venc_q;

    for (genvar g = 0; g < N_TEAMS; g++) begin : g_team
        logic [7:0] p8;
        logic [7:0] t8;
        logic [6:0] dez_q;
        logic [6:0] und_q;
        logic [6:0] tnt_seg_q;

        assign p8 = 8'(pts_q[g]);
        assign t8 = 8'(tnt_q[g]);

        assign pontos[g*PW +: PW]  = pts_q[g];
        assign tentos[g*TW +: TW]  = tnt_q[g];
        assign seg_dez[g*7 +: 7]   = dez_q;
        assign seg_und[g*7 +: 7]   = und_q;
        assign seg_tento[g*7 +: 7] = tnt_seg_q;

        always_ff @(posedge clk or negedge reset) begin
            if (!reset) begin
                dez_q     <= SEG7[0];
                und_q     <= SEG7[0];
                tnt_seg_q <= SEG7[0];
            end else begin
                dez_q     <= seg7_code(p8 / 8'd10);
                und_q     <= seg7_code(p8 % 8'd10);
                tnt_seg_q <= seg7_code(t8);
            end
        end
    end

endmodule

// File: tb/tb_truco_placar_multi.sv
// Self-checking bench: hand-computed event table, timed corner sequences,
// and random press events checked against an event-level scoreboard model.
module tb_truco_placar_multi;

    localparam int PTS  = 12;
    localparam int TMAX = 3;

    logic        clk = 1'b0;
    logic        reset;
    logic [2:0]  btn;
    logic        btn_truco;
    logic        novo_jogo;
    logic [11:0] pontos;
    logic [5:0]  tentos;
    logic [3:0]  valor_mao;
    logic        fim_jogo;
    logic [1:0]  vencedor;
    logic [20:0] seg_dez, seg_und, seg_tento;

    logic [1:0]  btn30;
    logic        truco30, novo30;
    logic [9:0]  pontos30;
    logic [3:0]  tentos30;
    logic [3:0]  valor30;
    logic        fim30;
    logic [1:0]  venc30;
    logic [13:0] dez30, und30, tnt30;

    always #5 clk = ~clk;

    truco_placar_multi #(.N_TEAMS(3), .PTS_MAX(PTS), .TENTOS_MAX(TMAX)) dut (
        .clk(clk), .reset(reset), .btn(btn), .btn_truco(btn_truco),
        .novo_jogo(novo_jogo), .pontos(pontos), .tentos(tentos),
        .valor_mao(valor_mao), .fim_jogo(fim_jogo), .vencedor(vencedor),
        .seg_dez(seg_dez), .seg_und(seg_und), .seg_tento(seg_tento)
    );

    truco_placar_multi #(.N_TEAMS(2), .PTS_MAX(30), .TENTOS_MAX(3)) dut30 (
        .clk(clk), .reset(reset), .btn(btn30), .btn_truco(truco30),
        .novo_jogo(novo30), .pontos(pontos30), .tentos(tentos30),
        .valor_mao(valor30), .fim_jogo(fim30), .vencedor(venc30),
        .seg_dez(dez30), .seg_und(und30), .seg_tento(tnt30)
    );

    int n_pass = 0;
    int n_total = 0;
    logic [6:0] tb_seg [10];

    int m_p [3];
    int m_t [3];
    int m_v, m_fim, m_venc;

    typedef struct {
        logic [4:0] m;   // {novo, truco, b2, b1, b0}
        int p0, p1, p2, t0, v;
    } vec_t;
    vec_t vecs [16];

    task automatic check(input string name, input int act, input int exp);
        n_total++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", name, act, exp);
    endtask

    function automatic int pt(input int i);
        return int'((pontos >> (4 * i)) & 12'hF);
    endfunction
    function automatic int tn(input int i);
        return int'((tentos >> (2 * i)) & 6'h3);
    endfunction
    function automatic int sg(input logic [20:0] bus, input int i);
        return int'((bus >> (7 * i)) & 21'h7F);
    endfunction

    function automatic void model_clear();
        for (int i = 0; i < 3; i++) begin
            m_p[i] = 0;
            m_t[i] = 0;
        end
        m_v = 1; m_fim = 0; m_venc = 0;
    endfunction

    // One press event as the rules describe it, including any round it completes.
    function automatic void model_event(input logic [4:0] m);
        int w;
        w = -1;
        if (m[4]) begin
            model_clear();
        end else if (m_fim == 0) begin
            for (int i = 0; i < 3; i++)
                if (m[i] && w < 0) w = i;
            if (w >= 0) begin
                m_p[w] = (m_p[w] + m_v > PTS) ? PTS : m_p[w] + m_v;
                m_v = 1;
                if (m_p[w] == PTS) begin
                    for (int i = 0; i < 3; i++) m_p[i] = 0;
                    m_t[w]++;
                    if (m_t[w] == TMAX) begin
                        m_fim = 1;
                        m_venc = w;
                    end
                end
            end else if (m[3]) begin
                m_v = (m_v == 1) ? 3 : ((m_v >= 12) ? 12 : m_v + 3);
            end
        end
    endfunction

    task automatic apply_event(input logic [4:0] m);
        @(negedge clk);
        btn = m[2:0]; btn_truco = m[3]; novo_jogo = m[4];
        repeat (2) @(negedge clk);
        btn = '0; btn_truco = 1'b0; novo_jogo = 1'b0;
        repeat (6) @(negedge clk);
        model_event(m);
    endtask

    task automatic apply30(input logic [3:0] m);
        @(negedge clk);
        btn30 = m[1:0]; truco30 = m[2]; novo30 = m[3];
        repeat (2) @(negedge clk);
        btn30 = '0; truco30 = 1'b0; novo30 = 1'b0;
        repeat (6) @(negedge clk);
    endtask

    task automatic compare_all(input string tag);
        for (int i = 0; i < 3; i++) begin
            check($sformatf("%s pontos%0d", tag, i), pt(i), m_p[i]);
            check($sformatf("%s tentos%0d", tag, i), tn(i), m_t[i]);
            check($sformatf("%s seg_und%0d", tag, i), sg(seg_und, i), int'(tb_seg[m_p[i] % 10]));
            check($sformatf("%s seg_dez%0d", tag, i), sg(seg_dez, i), int'(tb_seg[m_p[i] / 10]));
            check($sformatf("%s seg_tento%0d", tag, i), sg(seg_tento, i), int'(tb_seg[m_t[i]]));
        end
        check({tag, " valor_mao"}, int'(valor_mao), m_v);
        check({tag, " fim_jogo"}, int'(fim_jogo), m_fim);
        check({tag, " vencedor"}, int'(vencedor), m_venc);
    endtask

    initial begin
        tb_seg[0] = 7'b1000000; tb_seg[1] = 7'b1111001; tb_seg[2] = 7'b0100100;
        tb_seg[3] = 7'b0110000; tb_seg[4] = 7'b0011001; tb_seg[5] = 7'b0010010;
        tb_seg[6] = 7'b0000010; tb_seg[7] = 7'b1111000; tb_seg[8] = 7'b0000000;
        tb_seg[9] = 7'b0010000;

        vecs[0]  = '{5'b01000, 0, 0, 0, 0, 3};
        vecs[1]  = '{5'b01000, 0, 0, 0, 0, 6};
        vecs[2]  = '{5'b00010, 0, 6, 0, 0, 1};
        vecs[3]  = '{5'b00011, 1, 6, 0, 0, 1};
        vecs[4]  = '{5'b01001, 2, 6, 0, 0, 1};
        vecs[5]  = '{5'b01000, 2, 6, 0, 0, 3};
        vecs[6]  = '{5'b00100, 2, 6, 3, 0, 1};
        vecs[7]  = '{5'b01000, 2, 6, 3, 0, 3};
        vecs[8]  = '{5'b01000, 2, 6, 3, 0, 6};
        vecs[9]  = '{5'b01000, 2, 6, 3, 0, 9};
        vecs[10] = '{5'b01000, 2, 6, 3, 0, 12};
        vecs[11] = '{5'b01000, 2, 6, 3, 0, 12};
        vecs[12] = '{5'b00001, 0, 0, 0, 1, 1};
        vecs[13] = '{5'b10000, 0, 0, 0, 0, 1};
        vecs[14] = '{5'b01000, 0, 0, 0, 0, 3};
        vecs[15] = '{5'b11000, 0, 0, 0, 0, 1};

        reset = 1'b0;
        btn = '0; btn_truco = 1'b0; novo_jogo = 1'b0;
        btn30 = '0; truco30 = 1'b0; novo30 = 1'b0;
        model_clear();
        repeat (3) @(negedge clk);
        compare_all("reset");
        reset = 1'b1;
        repeat (2) @(negedge clk);

        for (int j = 0; j < 16; j++) begin
            apply_event(vecs[j].m);
            check($sformatf("vec%0d p0", j), pt(0), vecs[j].p0);
            check($sformatf("vec%0d p1", j), pt(1), vecs[j].p1);
            check($sformatf("vec%0d p2", j), pt(2), vecs[j].p2);
            check($sformatf("vec%0d t0", j), tn(0), vecs[j].t0);
            check($sformatf("vec%0d valor", j), int'(valor_mao), vecs[j].v);
        end

        // Saturating score at 10 + 3 with exact update and round timing.
        apply_event(5'b01000); apply_event(5'b01000); apply_event(5'b00001);
        apply_event(5'b01000); apply_event(5'b00001); apply_event(5'b00001);
        apply_event(5'b01000);
        check("pre-round p0", pt(0), 10);
        check("pre-round valor", int'(valor_mao), 3);
        @(negedge clk); btn[0] = 1'b1;
        @(posedge clk);
        repeat (2) @(posedge clk);
        #1 check("edge k+2 p0", pt(0), 10);
        @(posedge clk);
        #1 check("edge k+3 p0", pt(0), PTS);
        check("edge k+3 valor", int'(valor_mao), 1);
        check("edge k+3 t0", tn(0), 0);
        @(posedge clk);
        #1 check("rodada p0", pt(0), 0);
        check("rodada t0", tn(0), 1);
        @(negedge clk); btn = '0;
        repeat (6) @(negedge clk);
        model_event(5'b00001);
        compare_all("round");

        // Team 2 takes three tentos; the game then freezes until novo_jogo.
        apply_event(5'b10000);
        for (int r = 0; r < 3; r++) begin
            repeat (4) apply_event(5'b01000);
            apply_event(5'b00100);
            compare_all($sformatf("win%0d", r));
        end
        check("end fim_jogo", int'(fim_jogo), 1);
        check("end vencedor", int'(vencedor), 2);
        apply_event(5'b00001); apply_event(5'b01000); apply_event(5'b00010);
        compare_all("frozen");
        apply_event(5'b10000);
        compare_all("novo");
        check("novo fim_jogo", int'(fim_jogo), 0);

        // Holding a button counts once.
        @(negedge clk); btn[0] = 1'b1;
        repeat (50) @(negedge clk);
        btn = '0;
        repeat (6) @(negedge clk);
        model_event(5'b00001);
        check("held p0", pt(0), 1);
        compare_all("held");

        // Asynchronous reset between clock edges.
        apply_event(5'b01000); apply_event(5'b00001); apply_event(5'b00001);
        check("pre-reset p0", pt(0), 5);
        @(posedge clk);
        #2 reset = 1'b0;
        #1 check("async p0", pt(0), 0);
        check("async valor", int'(valor_mao), 1);
        check("async t0", tn(0), 0);
        @(negedge clk);
        @(negedge clk) reset = 1'b1;
        model_clear();
        @(posedge clk);
        #1 check("post-reset seg_und0", sg(seg_und, 0), 7'b1000000);
        compare_all("post-reset");

        // Two-digit display on the PTS_MAX=30 instance: 24 -> 27.
        repeat (4) apply30(4'b0100);
        apply30(4'b0001);
        repeat (4) apply30(4'b0100);
        apply30(4'b0001);
        check("d30 pre p0", int'(pontos30[4:0]), 24);
        apply30(4'b0100);
        @(negedge clk); btn30[0] = 1'b1;
        @(posedge clk);
        repeat (3) @(posedge clk);
        #1 check("d30 k+3 p0", int'(pontos30[4:0]), 27);
        check("d30 k+3 und lag", int'(und30[6:0]), int'(tb_seg[4]));
        @(posedge clk);
        #1 check("d30 dez", int'(dez30[6:0]), int'(tb_seg[2]));
        check("d30 und", int'(und30[6:0]), int'(tb_seg[7]));
        check("d30 tento", int'(tnt30[6:0]), int'(tb_seg[0]));
        @(negedge clk); btn30 = '0;

        // Random press events against the model.
        for (int e = 0; e < 60; e++) begin
            logic [4:0] m;
            m[0] = ($urandom_range(0, 99) < 25);
            m[1] = ($urandom_range(0, 99) < 20);
            m[2] = ($urandom_range(0, 99) < 20);
            m[3] = ($urandom_range(0, 99) < 55);
            m[4] = ($urandom_range(0, 99) < 4);
            apply_event(m);
            compare_all($sformatf("rnd%0d", e));
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
